// File: rtl/m72_sample_fetch.sv
// rtl/m72_sample_fetch.sv - sample ROM address generator, fetch engine and 8-bit DAC stage
//
// Ports:
//   CLK_32M, reset_n     clock, asynchronous active-low reset
//   sample_addr[7:0]     address byte from the sound core
//   sample_addr_wr[1:0]  bit0 loads addr[12:5], bit1 loads addr[20:13]; both clear addr[4:0]
//   sample_inc           latch sample_dac into pcm_raw and advance the address
//   sample_dac[7:0]      unsigned DAC byte (0x80 = silence)
//   sample_in[7:0]       ROM byte at the current address
//   sample_ready         sample_in valid; low stalls the sound core
//   rom_addr, rom_req    fetch address and level request to the sample ROM
//   rom_ack, rom_data    one-cycle acknowledge with data in the same cycle
//   pause                freezes the low-pass filter only
//   pcm_raw, pcm_filt    signed raw and one-pole filtered PCM
module m72_sample_fetch #(
  parameter int ROM_AW     = 18,
  parameter int FILT_SHIFT = 3
) (
  input  logic                CLK_32M,
  input  logic                reset_n,
  input  logic [7:0]          sample_addr,
  input  logic [1:0]          sample_addr_wr,
  input  logic                sample_inc,
  input  logic [7:0]          sample_dac,
  output logic [7:0]          sample_in,
  output logic                sample_ready,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic                rom_req,
  input  logic                rom_ack,
  input  logic [7:0]          rom_data,
  input  logic                pause,
  output logic signed [15:0]  pcm_raw,
  output logic signed [15:0]  pcm_filt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic [20:0]  addr;      // address presented on rom_addr
  logic [20:0]  tgt;       // address after every event seen so far
  logic [20:0]  tgt_upd;
  logic         restart, restart_nx;
  logic         event_now;
  logic         addr_ld;
  logic         capture;

  logic signed [16:0] diff;
  logic signed [16:0] step;

  assign event_now = (|sample_addr_wr) | sample_inc;

  // All events fold into tgt immediately; addr only follows tgt when no
  // request is outstanding (or on the ack that ends one), which keeps
  // rom_addr stable for the whole life of a request.
  always_comb begin
    tgt_upd = tgt;
    if (|sample_addr_wr) begin
      if (sample_addr_wr[0]) tgt_upd[12:5]  = sample_addr;
      if (sample_addr_wr[1]) tgt_upd[20:13] = sample_addr;
      tgt_upd[4:0] = 5'd0;
    end else if (sample_inc) begin
      tgt_upd = tgt + 21'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    restart_nx = restart;
    addr_ld    = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE, S_VALID: begin
        if (event_now) begin
          state_nx = S_REQ;
          addr_ld  = 1'b1;
        end
      end
      S_REQ: begin
        if (rom_ack) begin
          // A pending or same-cycle event makes this data stale: drop it
          // and re-issue at the updated address.
          if (restart || event_now) begin
            addr_ld    = 1'b1;
            restart_nx = 1'b0;
          end else begin
            capture  = 1'b1;
            state_nx = S_VALID;
          end
        end else if (event_now) begin
          restart_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      restart   <= 1'b0;
      addr      <= 21'd0;
      tgt       <= 21'd0;
      sample_in <= 8'hFF;
    end else begin
      state   <= state_nx;
      restart <= restart_nx;
      tgt     <= tgt_upd;
      if (addr_ld) addr <= tgt_upd;
      if (capture) sample_in <= rom_data;
    end
  end

  assign rom_req      = (state == S_REQ);
  assign rom_addr     = addr[ROM_AW-1:0];
  assign sample_ready = ((state == S_VALID) || (state == S_IDLE)) && !event_now;

  // One-pole low-pass: 17-bit difference so full-scale swings cannot wrap.
  always_comb begin
    diff = {pcm_raw[15], pcm_raw} - {pcm_filt[15], pcm_filt};
    step = diff >>> FILT_SHIFT;
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      pcm_raw  <= 16'sd0;
      pcm_filt <= 16'sd0;
    end else begin
      if (sample_inc) pcm_raw <= {sample_dac ^ 8'h80, 8'h00};
      if (!pause)     pcm_filt <= pcm_filt + step[15:0];
    end
  end

endmodule

// File: doc/m72_sample_fetch.md
# m72_sample_fetch

Sample-ROM address generator, fetch engine and 8-bit DAC stage for the M84-style sound path. It sits directly downstream of the Z80 sound core and consumes its `sample_addr`, `sample_addr_wr`, `sample_inc` and `sample_out` strobes. It returns `sample_in`/`sample_ready` to that core and fetches bytes from the sample ROM region through a req/ack memory port. It also produces signed raw and low-pass-filtered PCM for the audio mixer.

## Interface
Parameters:
- `ROM_AW`, 18: sample ROM byte-address width; the internal address is truncated to this.
- `FILT_SHIFT`, 3: one-pole filter coefficient, 2^-FILT_SHIFT.

Ports:
- `CLK_32M` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_addr` in 8: address byte; valid when `sample_addr_wr` is nonzero.
- `sample_addr_wr` in 2: 1-cycle strobe. Bit0 loads the low byte; bit1 loads the high byte.
- `sample_inc` in 1: 1-cycle strobe. Latch `sample_dac`, then advance the address.
- `sample_dac` in 8: unsigned DAC byte, 0x80 = silence.
- `sample_in` out 8: ROM byte at the current address.
- `sample_ready` out 1: `sample_in` is valid; the sound core stalls its Z80 while this is low.
- `rom_addr` out ROM_AW: fetch address.
- `rom_req` out 1: fetch request (level).
- `rom_ack` in 1: 1-cycle pulse; `rom_data` is valid in the same cycle.
- `rom_data` in 8: fetched byte.
- `pause` in 1: freezes the filter update only.
- `pcm_raw` out 16: signed DAC output.
- `pcm_filt` out 16: signed filtered output.

## Operation
- **Address register:** internal `addr[20:0]`.
  - Low write: `addr[12:5] <= sample_addr`, `addr[4:0] <= 0`; `addr[20:13]` is kept.
  - High write: `addr[20:13] <= sample_addr`, `addr[4:0] <= 0`; `addr[12:5]` is kept.
  - Both bits set in one cycle: both bytes load and `addr[4:0]` clears.
  - `sample_inc`: `addr <= addr + 1`, wrapping modulo 2^21.
  - `rom_addr = addr[ROM_AW-1:0]`.
- **Event:** any nonzero `sample_addr_wr` or `sample_inc`. If both occur in one cycle, the address write wins and the increment is dropped. The DAC latch still occurs.
- **Fetch FSM:**
  - IDLE (reset state): waiting for the first address write; `sample_ready=1`, `sample_in=0xFF`.
  - REQ: `rom_req=1` with `rom_addr` stable. Stays in REQ until `rom_ack`.
  - VALID: `sample_in` holds the byte; `sample_ready=1`.
  - Event in IDLE or VALID → REQ in the next cycle.
  - `rom_ack` in REQ with no pending restart → capture `rom_data` into `sample_in`, go to VALID.
- **Event while in REQ:** set `restart`. Hold `rom_req` high. On `rom_ack`, discard the data, clear `restart`, and stay in REQ with the updated address.
  - The address change is applied only after the ack, so `rom_addr` never changes while `rom_req` is high and unacknowledged.
  - Events are queued as address updates: at most one pending address-write value plus a pending increment count of 0–1. A second increment while one is pending is an error case, not covered.
- **`sample_ready`:** `(state==VALID | state==IDLE) & ~event`. It is combinational and drops in the event cycle itself.
- **DAC:**
  - On `sample_inc`: `pcm_raw <= {sample_dac ^ 8'h80, 8'h00}`.
  - Each cycle with `~pause`: `pcm_filt <= pcm_filt + ((pcm_raw - pcm_filt) >>> FILT_SHIFT)`. Use a 17-bit signed difference and arithmetic shift.
- **Reset values:** `addr=0`, state IDLE, `sample_in=0xFF`, `sample_ready=1`, `rom_req=0`, `pcm_raw=0`, `pcm_filt=0`, `restart=0`.
- **Reset mid-fetch:** `rom_req` drops immediately (asynchronous). A later stray `rom_ack` in IDLE is ignored.

## Timing
- Event at cycle N: `sample_ready=0` at N; `rom_req=1` with the new `rom_addr` from N+1.
- `rom_ack` at cycle M: `sample_in` updated and `sample_ready=1` at M+1; `rom_req=0` at M+1.
- Minimum event-to-ready latency is 2 cycles, with `rom_ack` at N+1.
- `rom_ack` in the same cycle as a new event: the data is discarded and REQ is re-issued with the new address from the next cycle. This follows the restart rule.
- `pcm_raw` updates 1 cycle after `sample_inc`. `pcm_filt` lags by its time constant.
- No combinational path from `rom_ack`/`rom_data` to any output.

## Test plan
- **Address load:** low write 0x12, then high write 0x34 → `rom_addr = 0x34<<13 | 0x12<<5 = 0x68240`, masked to 18 bits → 0x28240. ROM returns 0xA5 at ack → `sample_in=0xA5`, `sample_ready=1` one cycle after ack.
- **Increment chain:** from addr 0x001FFF, `sample_inc` with `sample_dac=0x00` → `rom_addr=0x2000`, `pcm_raw=0x8000`. Next inc with `sample_dac=0xFF` → `pcm_raw=0x7F00`, `rom_addr=0x2001`.
- **Wrap:** addr 0x1FFFFF, `sample_inc` → addr 0, `rom_addr=0`.
- **Restart:** event during REQ, with ack delayed 5 cycles → `rom_addr` unchanged until ack; the first data is discarded; a second REQ goes out at the new address; `sample_ready` stays low throughout.
- **Simultaneous:** `sample_addr_wr=2'b11` with data 0x01 and `sample_inc` in the same cycle → addr 0x002020 (no increment), `pcm_raw` latched.
- **Reset mid-fetch:** assert `reset_n=0` while `rom_req=1` → `rom_req=0` asynchronously, `sample_ready=1`, `sample_in=0xFF`. An ack after release is ignored. Filter: step `pcm_raw` to 0x7F00 with `FILT_SHIFT=3` → `pcm_filt` first step is 0x0FE0, monotonic toward 0x7F00; frozen while `pause=1`.
